// File: rtl/imm_gen_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Common: opcodes, immediate formats and decode result shared by the  |
// | immediate generator pipeline.                          Rev 1.0      |
// +----------------------------------------------------------------------+
package Common;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_REGIMM = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } Opcode;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } ImmFmt;

  // Results are built at the widest XLEN; narrower instances keep the low bits.
  localparam int XLEN_MAX = 64;
  typedef logic [XLEN_MAX-1:0] xword_t;

  typedef struct packed {
    xword_t imm;
    xword_t jimm;
    ImmFmt  fmt;
    logic   illegal;
  } ImmResult;

  function automatic int SHAMT_W(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen_pipe_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_decode_lane: combinational decode of one instruction into its   |
// | immediate, control-flow offset, format and illegal flag.  Rev 1.0    |
// +----------------------------------------------------------------------+
module imm_decode_lane
  import Common::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] i_insn,
  output ImmResult    o_res
);

  localparam int SW = SHAMT_W(XLEN);

  Opcode      w_opc;
  logic [2:0] w_f3;
  logic       w_shift;
  logic       w_shift_hi_ok;
  xword_t     w_i_imm;
  xword_t     w_s_imm;
  xword_t     w_b_imm;
  xword_t     w_j_imm;
  xword_t     w_u_imm;
  xword_t     w_sh_imm;

  assign w_opc   = Opcode'(i_insn[6:0]);
  assign w_f3    = i_insn[14:12];
  assign w_i_imm = {{52{i_insn[31]}}, i_insn[31:20]};
  assign w_s_imm = {{52{i_insn[31]}}, i_insn[31:25], i_insn[11:7]};
  assign w_b_imm = {{51{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
  assign w_j_imm = {{43{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};
  assign w_u_imm = {{32{i_insn[31]}}, i_insn[31:12], 12'h000};

  always_comb begin
    w_sh_imm         = '0;
    w_sh_imm[SW-1:0] = i_insn[20 +: SW];
  end

  // Upper shift-immediate bits may only be zero, or 0x10 for the arithmetic right shift.
  assign w_shift       = (w_opc == OP_REGIMM) && ((w_f3 == 3'd1) || (w_f3 == 3'd5));
  assign w_shift_hi_ok = (i_insn[31:26] == 6'h00) || ((i_insn[31:26] == 6'h10) && (w_f3 == 3'd5));

  always_comb begin
    o_res = '0;
    case (w_opc)
      OP_REGIMM: begin
        o_res.jimm = w_i_imm;
        if (w_shift) begin
          o_res.imm = w_sh_imm;
          o_res.fmt = FMT_SHAMT;
        end else begin
          o_res.imm = w_i_imm;
          o_res.fmt = FMT_I;
        end
      end
      OP_LOAD: begin
        o_res.imm = w_i_imm;
        o_res.fmt = FMT_I;
      end
      OP_STORE: begin
        o_res.imm = w_s_imm;
        o_res.fmt = FMT_S;
      end
      OP_BRANCH: begin
        o_res.jimm = w_b_imm;
        o_res.fmt  = FMT_B;
      end
      OP_JAL: begin
        o_res.imm  = 64'd4;
        o_res.jimm = w_j_imm;
        o_res.fmt  = FMT_J;
      end
      OP_JALR: begin
        o_res.imm  = 64'd4;
        o_res.jimm = w_i_imm;
        o_res.fmt  = FMT_I;
      end
      OP_LUI, OP_AUIPC: begin
        o_res.imm = w_u_imm;
        o_res.fmt = FMT_U;
      end
      default: ;
    endcase
    o_res.illegal = w_shift && (((XLEN == 32) && i_insn[25]) || !w_shift_hi_ok);
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_gen_pipe: multi-lane immediate decode feeding a 2-entry skid     |
// | FIFO with valid/ready handshakes on both sides.          Rev 1.0     |
// +----------------------------------------------------------------------+
module imm_gen_pipe
  import Common::*;
#(
  parameter int XLEN  = 32,
  parameter int LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [LANES-1:0]      i_lane_en,
  input  logic [LANES*32-1:0]   i_insn,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [LANES-1:0]      o_lane_en,
  output logic [LANES*XLEN-1:0] o_imm,
  output logic [LANES*XLEN-1:0] o_jimm,
  output logic [LANES*3-1:0]    o_fmt,
  output logic [LANES-1:0]      o_illegal
);

  ImmResult         w_dec [LANES];
  ImmResult         w_res [LANES];
  ImmResult         mem_res_q [2][LANES];
  logic [LANES-1:0] mem_en_q [2];
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             head_q;
  logic             head_d;
  logic             not_full_q;
  logic             w_tail;
  logic             w_push;
  logic             w_pop;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    imm_decode_lane #(.XLEN(XLEN)) u_dec (
      .i_insn (i_insn[l*32 +: 32]),
      .o_res  (w_dec[l])
    );

    assign w_res[l] = i_lane_en[l] ? w_dec[l] : '0;

    assign o_imm[l*XLEN +: XLEN]  = mem_res_q[head_q][l].imm[XLEN-1:0];
    assign o_jimm[l*XLEN +: XLEN] = mem_res_q[head_q][l].jimm[XLEN-1:0];
    assign o_fmt[l*3 +: 3]        = mem_res_q[head_q][l].fmt;
    assign o_illegal[l]           = mem_res_q[head_q][l].illegal;

    if (XLEN < XLEN_MAX) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^{mem_res_q[0][l].imm[XLEN_MAX-1:XLEN], mem_res_q[0][l].jimm[XLEN_MAX-1:XLEN],
                           mem_res_q[1][l].imm[XLEN_MAX-1:XLEN], mem_res_q[1][l].jimm[XLEN_MAX-1:XLEN]};
    end
  end

  // The flag is registered; reset only masks it so the block never accepts during reset.
  assign i_ready   = not_full_q & ~rst;
  assign o_valid   = (count_q != 2'd0);
  assign o_lane_en = mem_en_q[head_q];

  assign w_push = i_valid && i_ready;
  assign w_pop  = o_valid && o_ready;
  assign w_tail = head_q ^ count_q[0];

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (w_pop) begin
      head_d = ~head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      head_q     <= 1'b0;
      not_full_q <= 1'b1;
      for (int e = 0; e < 2; e++) begin
        mem_en_q[e] <= '0;
        for (int l = 0; l < LANES; l++) begin
          mem_res_q[e][l] <= '0;
        end
      end
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      not_full_q <= (count_d != 2'd2);
      if (w_push) begin
        mem_en_q[w_tail] <= i_lane_en;
        for (int l = 0; l < LANES; l++) begin
          mem_res_q[w_tail][l] <= w_res[l];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised successor to the single-lane immediate generator. For each of `LANES` instructions per beat, it decodes the data-path immediate (`imm`) and the control-flow offset (`jimm`) at `XLEN` width and tags each lane with an immediate format and an illegal flag. Stalls are replaced by a valid/ready handshake with a 2-entry skid buffer, so in-flight results are never lost. It sits between fetch/decode and the register-read stage.

## Interface
- `XLEN`, 32: data width; legal values are 32 and 64.
- `LANES`, 1: instructions per beat, 1..4.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `i_valid`  in  1: the input beat is valid.
- `i_ready`  out  1: the block accepts the beat this cycle.
- `i_lane_en`  in  LANES: per-lane enable within the beat.
- `i_insn`  in  LANES×32: raw instruction words.
- `o_valid`  out  1: the output beat is valid.
- `o_ready`  in  1: the consumer accepts the output beat.
- `o_lane_en`  out  LANES: registered copy of `i_lane_en`.
- `o_imm`  out  LANES×XLEN: data-path immediate per lane.
- `o_jimm`  out  LANES×XLEN: branch/jump offset per lane.
- `o_fmt`  out  LANES×3: `ImmFmt` per lane (NONE, I, S, B, U, J, SHAMT).
- `o_illegal`  out  LANES: the lane's immediate encoding is illegal.

## Operation
- Transfer occurs on `i_valid && i_ready` (input side) and `o_valid && o_ready` (output side).
- Per-lane `imm` by opcode:
  - RegImm with funct3 1/5: zero-extended shamt, `imm[SW-1:0]`, where SW is 5 for XLEN 32 and 6 for XLEN 64.
  - Other RegImm: sign-extended I-imm.
  - Jal, Jalr: constant 4.
  - Load: sign-extended I-imm.
  - Store: sign-extended {immhi, immlo}.
  - Lui, Auipc: {u.imm, 12'b0}, sign-extended from bit 31 to XLEN.
  - All other opcodes: 0.
- Per-lane `jimm` by opcode:
  - RegImm, Jalr: sign-extended I-imm.
  - Branch: sign-extended {imm4, imm3, imm2, imm1, 0}.
  - Jal: sign-extended {imm4, imm3, imm2, imm1, 0}.
  - All other opcodes: 0.
- `o_illegal` is set when:
  - XLEN=32, RegImm funct3 1/5, and `imm[5]`=1; or
  - RegImm funct3 1/5 and `imm[11:6]` is neither 0 nor 0x10 (the 0x10 value applies to funct3 5 only).
  - An illegal lane still outputs its computed `imm`.
- Lanes with `i_lane_en`=0 output `imm`=0, `jimm`=0, fmt NONE, and illegal=0.
- Skid buffer: a 2-entry FIFO holds the decoded beats, with decode placed before the buffer.
  - `i_ready` = !full, and it comes directly from a register.
  - `o_valid` = !empty.
  - Output fields are driven from the head entry.
- Simultaneous push and pop on a 1-entry buffer keeps the count at 1: the head advances and the new beat lands behind it.
- Push while full is impossible because `i_ready`=0. Pop while empty is ignored.

## Timing
- Latency: one cycle from input handshake to `o_valid` when the buffer is empty and `o_ready`=1.
- Sustained throughput is 1 beat/cycle while `o_ready`=1.
- `o_*` must hold stable while `o_valid && !o_ready`.
- Reset values:
  - In any cycle with `rst`=1: `i_ready`=0, and the buffer count is cleared.
  - From the first cycle after `rst` deasserts: `o_valid`=0, all `o_imm`/`o_jimm`/`o_lane_en`/`o_illegal`=0, `o_fmt`=NONE, `i_ready`=1.
- Reset mid-operation drops all buffered beats with no output handshake.
- `rst` overrides a simultaneous push or pop.

## Structure
- Shared package `Common` gains:
  - `ImmFmt` enum;
  - `ImmResult` packed struct {imm, jimm, fmt, illegal}, parametrised via XLEN-sized localparam typedefs;
  - `SHAMT_W(XLEN)` function.
- Opcode constants reuse the existing `Opcode` definitions.
- Sub-module `imm_decode_lane` is purely combinational: one instruction in, one `ImmResult` out. It is instantiated `LANES` times.
- The top level holds only the skid FIFO and the handshake logic.

## Test plan
- XLEN=32: ADDI x1,x0,-1 (0xFFF00093), consumer always ready → next cycle `o_valid`=1, imm=0xFFFFFFFF, fmt=I, illegal=0.
- XLEN=64: SLLI x1,x1,63 (0x03F09093) → imm=63, illegal=0. The same word at XLEN=32 → imm=31, illegal=1.
- XLEN=64: LUI x1,0x80000 (0x800000B7) → imm=0xFFFFFFFF80000000. BEQ x0,x0,-4 (0xFE000EE3) → jimm=0xFFFFFFFFFFFFFFFC, imm=0.
- LANES=2, beat {JAL x0,0 (0x0000006F), lane1 disabled} → lane0 imm=4, jimm=0, fmt=J; lane1 all-zero, fmt NONE.
- Backpressure sequence:
  - Hold `o_ready`=0 and push 2 beats → `i_ready` drops on the cycle after the second push, and outputs stay stable.
  - Release `o_ready` → both beats appear in order on consecutive cycles, and `i_ready` rises after the first pop.
- Assert `rst` with 2 beats buffered → next cycle `o_valid`=0 and outputs are 0. After deassert, `i_ready`=1 and no stale beat appears.
